pipeline_fetch_issue: RTL and testbench

//  Front end of the 4-stage pipeline: owns the PC, fetches from synchronous instruction memory and shifts

---
 rtl/pipeline_fetch_issue.sv | 172 +++++++++++++++++
 tb/tb_pipeline_fetch_issue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fetch_issue.sv
// Pipeline front end: PC, synchronous imem fetch, stage registers inst_ipipe[1:4],
// stall/squash/redirect FSM. Optional perf counters under `define PIPE_PERF_CNT_EN.
module pipeline_fetch_issue #(
    parameter int                PC_W     = 16,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [15:0]       BUBBLE   = 16'h001F,
    parameter int                CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [PC_W-1:0]      imem_addr,
    output logic                 imem_ren,
    input  logic [15:0]          imem_rdata,
    input  logic                 hold_in_decode_state,
    input  logic                 pc_enable,
    input  logic                 br_resolve,
    input  logic                 br_taken,
    input  logic [PC_W-1:0]      br_target,
    output logic [1:4][15:0]     inst_ipipe,
    output logic [1:4][4:0]      opcode,
    output logic [PC_W-1:0]      pc_ex,
    output logic [1:0]           state_dbg,
    output logic [CNT_W-1:0]     perf_stall_cnt,
    output logic [CNT_W-1:0]     perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        REFILL  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

    state_t                 state, state_nxt;
    logic [PC_W-1:0]        pc, pc_f;
    logic [1:3][PC_W-1:0]   pc_pipe;
    logic [1:4][15:0]       ipipe;
    logic                   do_hold, do_squash, do_adv, do_redirect;
    logic [PC_W-1:0]        pc_redirect;

    assign imem_addr = pc;
    assign inst_ipipe = ipipe;
    assign pc_ex = pc_pipe[3];
    assign state_dbg = state;
    assign pc_redirect = br_taken ? br_target : pc_pipe[3] + PC_STEP;

    for (genvar i = 1; i <= 4; i++) begin : g_opc
        assign opcode[i] = ipipe[i][4:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= REFILL;
        else       state <= state_nxt;
    end

    // Stall beats squash; a bubble in stage 2 can never be a branch.
    always_comb begin
        state_nxt   = state;
        imem_ren    = 1'b0;
        do_hold     = 1'b0;
        do_squash   = 1'b0;
        do_adv      = 1'b0;
        do_redirect = 1'b0;
        case (state)
            REFILL: begin
                imem_ren  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (hold_in_decode_state) begin
                    do_hold = 1'b1;
                end else if (!pc_enable && ipipe[2] != BUBBLE) begin
                    do_squash = 1'b1;
                    state_nxt = BR_WAIT;
                end else begin
                    imem_ren = 1'b1;
                    do_adv   = 1'b1;
                end
            end
            BR_WAIT: begin
                if (br_resolve) begin
                    do_redirect = 1'b1;
                    state_nxt   = REFILL;
                end
            end
            default: state_nxt = REFILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            pc_f    <= '0;
            pc_pipe <= '0;
            ipipe   <= {4{BUBBLE}};
        end else begin
            case (state)
                REFILL: begin
                    ipipe[1]   <= BUBBLE;
                    ipipe[2]   <= ipipe[1];
                    ipipe[3]   <= ipipe[2];
                    ipipe[4]   <= ipipe[3];
                    pc_pipe[2] <= pc_pipe[1];
                    pc_pipe[3] <= pc_pipe[2];
                    pc_f       <= pc;
                    pc         <= pc + PC_STEP;
                end
                RUN: begin
                    if (do_hold) begin
                        // Execute gets a bubble; pc_pipe[3] keeps the last real PC.
                        ipipe[4] <= ipipe[3];
                        ipipe[3] <= BUBBLE;
                    end else if (do_squash) begin
                        ipipe[4]   <= ipipe[3];
                        ipipe[3]   <= ipipe[2];
                        ipipe[2]   <= BUBBLE;
                        ipipe[1]   <= BUBBLE;
                        pc_pipe[3] <= pc_pipe[2];
                    end else if (do_adv) begin
                        ipipe[1]   <= imem_rdata;
                        ipipe[2]   <= ipipe[1];
                        ipipe[3]   <= ipipe[2];
                        ipipe[4]   <= ipipe[3];
                        pc_pipe[1] <= pc_f;
                        pc_pipe[2] <= pc_pipe[1];
                        pc_pipe[3] <= pc_pipe[2];
                        pc_f       <= pc;
                        pc         <= pc + PC_STEP;
                    end
                end
                BR_WAIT: begin
                    // pc_pipe[3] frozen so pc_ex still names the branch at resolve.
                    ipipe[4] <= ipipe[3];
                    ipipe[3] <= BUBBLE;
                    ipipe[2] <= BUBBLE;
                    ipipe[1] <= BUBBLE;
                    if (do_redirect) pc <= pc_redirect;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             refill_from_br;
    logic             stall_inc, flush_inc;

    assign stall_inc = (state == RUN) && hold_in_decode_state;
    assign flush_inc = (state == BR_WAIT) || ((state == REFILL) && refill_from_br);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt      <= '0;
            flush_cnt      <= '0;
            refill_from_br <= 1'b0;
        end else begin
            refill_from_br <= do_redirect;
            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_fetch_issue.sv
// Directed bench for pipeline_fetch_issue: reset, straight-line fetch, hold, taken/not-taken branch.
module tb_pipeline_fetch_issue;

    localparam logic [15:0] BUB = 16'h001F;
`ifdef PIPE_PERF_CNT_EN
    localparam int STALL_EXP = 3;
    localparam int FLUSH_EXP = 2;
`else
    localparam int STALL_EXP = 0;
    localparam int FLUSH_EXP = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       imem_addr;
    logic              imem_ren;
    logic [15:0]       imem_rdata = '0;
    logic              hold_in_decode_state, pc_enable;
    logic              br_resolve, br_taken;
    logic [15:0]       br_target;
    logic [1:4][15:0]  inst_ipipe;
    logic [1:4][4:0]   opcode;
    logic [15:0]       pc_ex;
    logic [1:0]        state_dbg;
    logic [15:0]       perf_stall_cnt, perf_flush_cnt;
    logic [15:0]       mem [0:255];
    int                checks = 0;
    int                fails = 0;

    pipeline_fetch_issue dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_ren(imem_ren), .imem_rdata(imem_rdata),
        .hold_in_decode_state(hold_in_decode_state), .pc_enable(pc_enable),
        .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target),
        .inst_ipipe(inst_ipipe), .opcode(opcode), .pc_ex(pc_ex), .state_dbg(state_dbg),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // Word at byte address 2k is 16'h1000+k, so opcode = k (never the bubble opcode here).
    initial for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);

    always @(posedge clk) if (imem_ren) imem_rdata <= mem[imem_addr[8:1]];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; hold_in_decode_state = 1'b0; pc_enable = 1'b1;
        br_resolve = 1'b0; br_taken = 1'b0; br_target = '0;
        tick(); tick();
        chk("rst_addr", imem_addr, 16'h0);
        chk("rst_ipipe1", inst_ipipe[1], BUB);
        chk("rst_ipipe4", inst_ipipe[4], BUB);
        chk("rst_state", state_dbg, 2);
        chk("rst_ren", imem_ren, 1);
        chk("rst_pc_ex", pc_ex, 0);
        chk("rst_stall", perf_stall_cnt, 0);
        reset = 1'b0;

        // Straight-line fetch; pc_enable=0 while stage 2 holds a bubble must be ignored
        pc_enable = 1'b0;
        tick();  // E1
        chk("e1_addr", imem_addr, 16'h2);
        chk("e1_state", state_dbg, 0);
        tick();  // E2
        chk("e2_ipipe1", inst_ipipe[1], 16'h1000);
        chk("e2_addr", imem_addr, 16'h4);
        pc_enable = 1'b1;
        tick();  // E3
        chk("e3_ipipe2", inst_ipipe[2], 16'h1000);
        chk("e3_state", state_dbg, 0);
        tick();  // E4
        chk("e4_ipipe3", inst_ipipe[3], 16'h1000);
        chk("e4_pc_ex", pc_ex, 16'h0);
        tick();  // E5
        chk("e5_ipipe4", inst_ipipe[4], 16'h1000);
        chk("e5_ipipe2", inst_ipipe[2], 16'h1002);
        chk("e5_pc_ex", pc_ex, 16'h2);

        // Three hold cycles with I2 in stage 2
        hold_in_decode_state = 1'b1;
        #1 chk("hold_ren", imem_ren, 0);
        tick();  // E6
        chk("h1_ipipe3", inst_ipipe[3], BUB);
        chk("h1_ipipe4", inst_ipipe[4], 16'h1001);
        chk("h1_ipipe1", inst_ipipe[1], 16'h1003);
        chk("h1_ipipe2", inst_ipipe[2], 16'h1002);
        chk("h1_addr", imem_addr, 16'hA);
        tick();  // E7
        chk("h2_ipipe3", inst_ipipe[3], BUB);
        chk("h2_ipipe4", inst_ipipe[4], BUB);
        tick();  // E8
        chk("h3_ipipe3", inst_ipipe[3], BUB);
        chk("h3_ipipe1", inst_ipipe[1], 16'h1003);
        hold_in_decode_state = 1'b0;
        tick();  // E9
        chk("r1_ipipe3", inst_ipipe[3], 16'h1002);
        chk("r1_ipipe1", inst_ipipe[1], 16'h1004);
        chk("r1_ipipe4", inst_ipipe[4], BUB);
        chk("r1_pc_ex", pc_ex, 16'h4);
        tick();  // E10
        chk("r2_ipipe3", inst_ipipe[3], 16'h1003);
        chk("r2_ipipe4", inst_ipipe[4], 16'h1002);
        tick();  // E11
        chk("r3_ipipe3", inst_ipipe[3], 16'h1004);
        chk("perf_stall", perf_stall_cnt, STALL_EXP);
        chk("perf_flush0", perf_flush_cnt, 0);

        // Reset mid-cycle takes effect immediately
        #2 reset = 1'b1;
        #1;
        chk("mr_addr", imem_addr, 16'h0);
        chk("mr_opcode", opcode, {4{5'h1F}});
        chk("mr_state", state_dbg, 2);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("mr_ipipe1", inst_ipipe[1], 16'h1000);
        chk("mr_stall_clr", perf_stall_cnt, 0);

        // Taken branch at address 4, target 0x20
        tick(); tick(); tick();  // E3..E5
        chk("bt_ipipe2", inst_ipipe[2], 16'h1002);
        pc_enable = 1'b0;
        tick();  // E6
        chk("bt_state_w", state_dbg, 1);
        chk("bt_ipipe3", inst_ipipe[3], 16'h1002);
        chk("bt_ipipe2b", inst_ipipe[2], BUB);
        chk("bt_ipipe1b", inst_ipipe[1], BUB);
        chk("bt_pc_ex", pc_ex, 16'h4);
        pc_enable = 1'b1; br_resolve = 1'b1; br_taken = 1'b1; br_target = 16'h20;
        tick();  // E7
        chk("bt_state_r", state_dbg, 2);
        chk("bt_addr", imem_addr, 16'h20);
        chk("bt_ren", imem_ren, 1);
        chk("bt_ipipe4", inst_ipipe[4], 16'h1002);
        chk("bt_b1", inst_ipipe[3], BUB);
        br_resolve = 1'b0;
        tick();  // E8
        chk("bt_b2", inst_ipipe[3], BUB);
        // br_resolve outside BR_WAIT has no effect
        br_resolve = 1'b1; br_target = 16'h40;
        tick();  // E9
        chk("bt_b3", inst_ipipe[3], BUB);
        chk("bt_ipipe1t", inst_ipipe[1], 16'h1010);
        chk("bt_ign_res", imem_addr, 16'h24);
        br_resolve = 1'b0;
        tick();  // E10
        chk("bt_b4", inst_ipipe[3], BUB);
        tick();  // E11
        chk("bt_target", inst_ipipe[3], 16'h1010);
        chk("bt_pc_ex_t", pc_ex, 16'h20);
        chk("perf_flush", perf_flush_cnt, FLUSH_EXP);
        chk("perf_stall0", perf_stall_cnt, 0);

        // Not-taken branch at address 4: fetch resumes at 6
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();  // E1..E5
        pc_enable = 1'b0;
        tick();  // E6
        pc_enable = 1'b1; br_resolve = 1'b1; br_taken = 1'b0; br_target = 16'h20;
        tick();  // E7
        chk("bn_addr", imem_addr, 16'h6);
        br_resolve = 1'b0;
        tick(); tick(); tick();  // E8..E10
        chk("bn_bub", inst_ipipe[3], BUB);
        tick();  // E11
        chk("bn_ipipe3", inst_ipipe[3], 16'h1003);
        chk("bn_pc_ex", pc_ex, 16'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
